// File: rtl/mxfp8_block_quantizer.sv
// mxfp8_block_quantizer
// Buffers BLOCK_SIZE BF16 results, derives one shared E8M0 scale from the
// largest finite exponent, then streams the elements out re-encoded as E4M3.
//
// Handshake rule on both sides: a transfer happens on a rising edge where
// valid && ready are both high; valid never depends on ready, and a presented
// output (data/scale/last) stays unchanged until it has been transferred.
module mxfp8_block_quantizer #(
    parameter int BLOCK_SIZE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic [7:0]  out_scale,
    output logic        out_last,
    output logic        dbg_state
);

    localparam int IDX_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_SIZE - 1);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_EMIT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [7:0]       max_e_q, max_e_d;
    logic             nan_flag_q, nan_flag_d;
    logic [7:0]       scale_q, scale_d;
    logic [15:0]      data_buf_q [BLOCK_SIZE];
    logic [15:0]      data_buf_d [BLOCK_SIZE];

    logic       in_fire;
    logic       out_fire;
    logic [7:0] in_exp;
    logic [7:0] max_next;
    logic       nan_next;

    // BF16 -> E4M3 with the block scale removed; RNE rounding, saturating to 448.
    function automatic logic [7:0] encode_e4m3(input logic [15:0] x,
                                               input logic [7:0]  scale,
                                               input logic        nan);
        logic              s;
        logic [7:0]        e;
        logic [6:0]        m;
        logic signed [9:0] u;
        logic signed [9:0] eb;
        logic [3:0]        mr;
        logic              up;
        logic [9:0]        sh_raw;
        logic [3:0]        sh;
        logic [17:0]       wide;
        logic [7:0]        ms;
        logic [7:0]        res;
        s      = x[15];
        e      = x[14:7];
        m      = x[6:0];
        u      = $signed({2'b00, e}) - $signed({2'b00, scale});
        eb     = '0;
        mr     = '0;
        up     = 1'b0;
        sh_raw = '0;
        sh     = '0;
        wide   = '0;
        ms     = '0;
        res    = {s, 7'h00};
        if (nan) begin
            res = {s, 7'h7F};
        end else if (e == 8'd0) begin
            res = {s, 7'h00};
        end else if (u >= -10'sd6) begin
            // Normal: keep 3 of 7 mantissa bits, guard = m[3], sticky = m[2:0].
            up = m[3] & ((|m[2:0]) | m[4]);
            mr = {1'b0, m[6:4]} + {3'b000, up};
            eb = u + 10'sd7 + (mr[3] ? 10'sd1 : 10'sd0);
            if ((eb > 10'sd15) || ((eb == 10'sd15) && (mr[2:0] == 3'b111))) begin
                res = {s, 7'h7E};
            end else begin
                res = {s, eb[3:0], mr[2:0]};
            end
        end else begin
            // Subnormal: integer count of 2^-9 units is {1,M7} >> (4 + (-6-u)).
            sh_raw = 10'(-10'sd2 - u);
            sh     = (sh_raw > 10'd12) ? 4'd12 : sh_raw[3:0];
            wide   = {1'b1, m, 10'b0} >> sh;
            ms     = wide[17:10];
            up     = wide[9] & ((|wide[8:0]) | ms[0]);
            ms     = ms + {7'b0, up};
            res    = {s, ms[6:0]};
        end
        return res;
    endfunction

    assign in_ready  = rst_n && (state_q == ST_FILL);
    assign out_valid = (state_q == ST_EMIT);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign in_exp    = in_data[14:7];
    assign dbg_state = state_q;

    // Running exponent max / Inf-NaN tracking including the element now arriving.
    always_comb begin
        max_next = max_e_q;
        nan_next = nan_flag_q;
        if (in_exp == 8'hFF) begin
            nan_next = 1'b1;
        end else if (in_exp > max_e_q) begin
            max_next = in_exp;
        end
    end

    // Next-state logic for the FILL/EMIT controller and its counters.
    always_comb begin
        state_d    = state_q;
        wr_idx_d   = wr_idx_q;
        rd_idx_d   = rd_idx_q;
        max_e_d    = max_e_q;
        nan_flag_d = nan_flag_q;
        scale_d    = scale_q;
        case (state_q)
            ST_FILL: begin
                if (in_fire) begin
                    wr_idx_d   = wr_idx_q + 1'b1;
                    max_e_d    = max_next;
                    nan_flag_d = nan_next;
                    if (wr_idx_q == LAST_IDX) begin
                        state_d  = ST_EMIT;
                        rd_idx_d = '0;
                        wr_idx_d = '0;
                        scale_d  = nan_next ? 8'hFF :
                                   ((max_next > 8'd8) ? (max_next - 8'd8) : 8'd0);
                    end
                end
            end
            ST_EMIT: begin
                if (out_fire) begin
                    rd_idx_d = rd_idx_q + 1'b1;
                    if (rd_idx_q == LAST_IDX) begin
                        state_d    = ST_FILL;
                        rd_idx_d   = '0;
                        wr_idx_d   = '0;
                        max_e_d    = '0;
                        nan_flag_d = 1'b0;
                    end
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    // Element buffer write port.
    always_comb begin
        data_buf_d = data_buf_q;
        if (in_fire) begin
            data_buf_d[wr_idx_q] = in_data;
        end
    end

    // Output element encoding; outputs idle at zero outside EMIT.
    always_comb begin
        out_data  = 8'h00;
        out_last  = 1'b0;
        out_scale = scale_q;
        if (state_q == ST_EMIT) begin
            out_data = encode_e4m3(data_buf_q[rd_idx_q], scale_q, nan_flag_q);
            out_last = (rd_idx_q == LAST_IDX);
        end
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_FILL;
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            max_e_q    <= '0;
            nan_flag_q <= 1'b0;
            scale_q    <= '0;
        end else begin
            state_q    <= state_d;
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
            max_e_q    <= max_e_d;
            nan_flag_q <= nan_flag_d;
            scale_q    <= scale_d;
        end
    end

    // Data buffer needs no reset: it is only read after a full block is written.
    always_ff @(posedge clk) begin
        data_buf_q <= data_buf_d;
    end

endmodule

// File: tb/tb_mxfp8_block_quantizer.sv
// Self-checking bench for mxfp8_block_quantizer: directed blocks with
// hand-computed E4M3 results, a queue of expected outputs, and a monitor.
module tb_mxfp8_block_quantizer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [7:0]  out_scale;
    logic        out_last;
    logic        dbg_state;

    // {last, scale, data}
    logic [16:0] exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    int stall_elem = -1;
    int stall_left = 0;
    int elem_idx   = 0;

    mxfp8_block_quantizer #(.BLOCK_SIZE(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_scale (out_scale),
        .out_last  (out_last),
        .dbg_state (dbg_state)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Driver: called on a negedge, returns on the negedge after the accept edge.
    task automatic send(input logic [15:0] d);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready never rose for 0x%0h", d);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Pushes the expected block then drives its four elements (element 0 in MSBs).
    task automatic send_block(input logic [63:0] d, input logic [31:0] e,
                              input logic [7:0] sc, input int max_gap);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({(i == 3), sc, e[(3-i)*8 +: 8]});
        end
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, max_gap)) @(negedge clk);
            send(d[(3-i)*16 +: 16]);
        end
        check("latency_out_valid", 32'(out_valid), 32'd1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d expected elements never appeared", exp_q.size());
        end
        @(negedge clk);
        check("idle_after_block", 32'(out_valid), 32'd0);
        check("in_ready_after_block", 32'(in_ready), 32'd1);
    endtask

    // Monitor / scoreboard: owns out_ready and compares every presented element.
    always @(negedge clk) begin
        logic [16:0] exp;
        if (rst_n !== 1'b1) begin
            elem_idx  = 0;
            out_ready = 1'b1;
        end else if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: data 0x%0h scale 0x%0h with empty queue",
                         out_data, out_scale);
                out_ready = 1'b1;
            end else if (stall_elem == elem_idx && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
                exp = exp_q[0];
                check("stall_data_stable", 32'(out_data), 32'(exp[7:0]));
                check("stall_scale_stable", 32'(out_scale), 32'(exp[15:8]));
                check("stall_in_ready_low", 32'(in_ready), 32'd0);
            end else begin
                out_ready = 1'b1;
                exp = exp_q.pop_front();
                check("out_data", 32'(out_data), 32'(exp[7:0]));
                check("out_scale", 32'(out_scale), 32'(exp[15:8]));
                check("out_last", 32'(out_last), 32'(exp[16]));
                elem_idx = exp[16] ? 0 : elem_idx + 1;
            end
        end else begin
            out_ready = 1'b1;
        end
    end

    // Stimulus
    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", 32'(out_data), 32'd0);
        check("reset_out_scale", 32'(out_scale), 32'd0);
        check("reset_out_last", 32'(out_last), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", 32'(in_ready), 32'd1);

        // 1.0 x4: scale 2^-8, each element 2^8 -> 0x78
        send_block({16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80},
                   {8'h78, 8'h78, 8'h78, 8'h78}, 8'h77, 0);
        wait_drain();

        // Mixed magnitudes and a zero
        send_block({16'h4000, 16'hBF80, 16'h3F00, 16'h0000},
                   {8'h78, 8'hF0, 8'h68, 8'h00}, 8'h78, 0);
        wait_drain();

        // Saturation after carry, tie to even, tie rounding up
        send_block({16'h3FFF, 16'h3FC8, 16'h3FD8, 16'h3F80},
                   {8'h7E, 8'h7C, 8'h7E, 8'h78}, 8'h77, 0);
        wait_drain();

        // Smallest normal, subnormal, flush to zero
        send_block({16'h3F80, 16'h3880, 16'h3800, 16'h3600},
                   {8'h78, 8'h08, 8'h04, 8'h00}, 8'h77, 0);
        wait_drain();

        // NaN / Inf poison the whole block
        send_block({16'h7FC0, 16'hBF80, 16'h7F80, 16'h3F80},
                   {8'h7F, 8'hFF, 8'h7F, 8'h7F}, 8'hFF, 0);
        wait_drain();

        // Back-pressure: hold element 1 for 3 cycles
        stall_elem = 1;
        stall_left = 3;
        send_block({16'h4000, 16'hBF80, 16'h3F00, 16'h0000},
                   {8'h78, 8'hF0, 8'h68, 8'h00}, 8'h78, 0);
        wait_drain();
        check("stall_consumed", 32'(stall_left), 32'd0);
        stall_elem = -1;

        // Random input gaps give the same result as gap-free
        send_block({16'h3FFF, 16'h3FC8, 16'h3FD8, 16'h3F80},
                   {8'h7E, 8'h7C, 8'h7E, 8'h78}, 8'h77, 3);
        wait_drain();

        // Reset after two accepts discards the partial block
        send(16'h4000);
        send(16'h7FC0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midfill_reset_in_ready", 32'(in_ready), 32'd0);
        check("midfill_reset_out_valid", 32'(out_valid), 32'd0);
        check("midfill_reset_out_scale", 32'(out_scale), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        send_block({16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80},
                   {8'h78, 8'h78, 8'h78, 8'h78}, 8'h77, 0);
        wait_drain();

        repeat (5) @(negedge clk);
        check("final_idle", 32'(out_valid), 32'd0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
